// File: rtl/debounce_edge_detect.sv
// Two-flop synchroniser and debounce FSM for a single flopped bit.
// Emits a clean level, one-cycle rise/fall pulses and a wrapping rising-edge count.
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_LOW       | accepted level 0, d_sync agrees
// ST_WAIT_HIGH | accepted level 0, d_sync has been 1 for stab_cnt samples
// ST_HIGH      | accepted level 1, d_sync agrees
// ST_WAIT_LOW  | accepted level 1, d_sync has been 0 for stab_cnt samples
module debounce_edge_detect #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 d_in,
    input  logic                 cnt_clr_in,
    output logic                 q_out,
    output logic                 rise_out,
    output logic                 fall_out,
    output logic [CNT_WIDTH-1:0] edge_cnt_out
);

    localparam int            SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] TC = SW'(STABLE_CYCLES - 1);

    // Three-bit encoding leaves spare codes; they fall into the default arm.
    typedef enum logic [2:0] {
        ST_LOW       = 3'b000,
        ST_WAIT_HIGH = 3'b001,
        ST_HIGH      = 3'b010,
        ST_WAIT_LOW  = 3'b011
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] stab_cnt;
    logic [SW-1:0] stab_cnt_nxt;
    logic          sync1;
    logic          sync2;
    logic          d_sync;
    logic          q_nxt;
    logic          rise_nxt;
    logic          fall_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= d_in;
            sync2 <= sync1;
        end
    end

    assign d_sync = sync2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_LOW;
            stab_cnt <= '0;
            q_out    <= 1'b0;
            rise_out <= 1'b0;
            fall_out <= 1'b0;
        end else begin
            state    <= state_nxt;
            stab_cnt <= stab_cnt_nxt;
            q_out    <= q_nxt;
            rise_out <= rise_nxt;
            fall_out <= fall_nxt;
        end
    end

    always_comb begin
        state_nxt    = ST_LOW;
        stab_cnt_nxt = '0;
        q_nxt        = 1'b0;
        rise_nxt     = 1'b0;
        fall_nxt     = 1'b0;
        case (state)
            ST_LOW: begin
                if (d_sync) begin
                    state_nxt    = ST_WAIT_HIGH;
                    stab_cnt_nxt = SW'(1);
                end
            end
            ST_WAIT_HIGH: begin
                if (!d_sync) begin
                    state_nxt = ST_LOW;
                end else if (stab_cnt == TC) begin
                    state_nxt = ST_HIGH;
                    q_nxt     = 1'b1;
                    rise_nxt  = 1'b1;
                end else begin
                    state_nxt    = ST_WAIT_HIGH;
                    stab_cnt_nxt = stab_cnt + SW'(1);
                end
            end
            ST_HIGH: begin
                q_nxt = 1'b1;
                if (!d_sync) begin
                    state_nxt    = ST_WAIT_LOW;
                    stab_cnt_nxt = SW'(1);
                end else begin
                    state_nxt = ST_HIGH;
                end
            end
            ST_WAIT_LOW: begin
                q_nxt = 1'b1;
                if (d_sync) begin
                    state_nxt = ST_HIGH;
                end else if (stab_cnt == TC) begin
                    state_nxt = ST_LOW;
                    q_nxt     = 1'b0;
                    fall_nxt  = 1'b1;
                end else begin
                    state_nxt    = ST_WAIT_LOW;
                    stab_cnt_nxt = stab_cnt + SW'(1);
                end
            end
            default: begin
                state_nxt = ST_LOW;
            end
        endcase
    end

    // Clear takes priority over a coincident rise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cnt_out <= '0;
        end else if (cnt_clr_in) begin
            edge_cnt_out <= '0;
        end else if (rise_nxt) begin
            edge_cnt_out <= edge_cnt_out + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Self-checking bench for debounce_edge_detect: directed scenarios plus random
// stimulus, all checked against a run-length reference model.
module tb_debounce_edge_detect;

    localparam int STABLE = 4;
    localparam int CW     = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          d_in = 1'b0;
    logic          cnt_clr_in = 1'b0;
    logic          q_out;
    logic          rise_out;
    logic          fall_out;
    logic [CW-1:0] edge_cnt_out;

    int total = 0;
    int bad   = 0;

    debounce_edge_detect #(.STABLE_CYCLES(STABLE), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .d_in         (d_in),
        .cnt_clr_in   (cnt_clr_in),
        .q_out        (q_out),
        .rise_out     (rise_out),
        .fall_out     (fall_out),
        .edge_cnt_out (edge_cnt_out)
    );

    always #5 clk = ~clk;

    // Reference: two-sample delay, then accept a new level once it has been seen
    // STABLE times in a row; count accepted rises modulo 2^CW, clear wins.
    logic          s1, s2, m_q, m_rise, m_fall;
    int            run;
    logic [CW-1:0] m_cnt;
    bit            m_flip;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 0; s2 <= 0; m_q <= 0; m_rise <= 0; m_fall <= 0; run <= 0; m_cnt <= 0;
        end else begin
            m_flip = (s2 != m_q) && (run + 1 == STABLE);
            s1 <= d_in;
            s2 <= s1;
            m_rise <= m_flip && s2;
            m_fall <= m_flip && !s2;
            if (m_flip) begin
                m_q <= s2;
                run <= 0;
            end else if (s2 != m_q) begin
                run <= run + 1;
            end else begin
                run <= 0;
            end
            if (cnt_clr_in) m_cnt <= '0;
            else if (m_flip && s2) m_cnt <= CW'((int'(m_cnt) + 1) % (1 << CW));
        end
    end

    task automatic test_reset();
        reset_n = 0; d_in = 0; cnt_clr_in = 0;
        repeat (2) @(negedge clk);
        reset_n = 1;
        d_in = 1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            total++;
            if ({q_out, rise_out, fall_out, edge_cnt_out} !== {m_q, m_rise, m_fall, m_cnt}) begin
                bad++;
                $display("FAIL reset_prefill k=%0d got q%b r%b f%b c%0d want q%b r%b f%b c%0d",
                         k, q_out, rise_out, fall_out, edge_cnt_out, m_q, m_rise, m_fall, m_cnt);
            end
        end
        total++;
        if (q_out !== 1'b1) begin
            bad++;
            $display("FAIL reset_prefill_q got %b want 1", q_out);
        end
        @(posedge clk);
        #2 reset_n = 0;
        #1;
        total++;
        if ({q_out, rise_out, fall_out, edge_cnt_out} !== '0) begin
            bad++;
            $display("FAIL reset_async got q%b r%b f%b c%0d want all 0",
                     q_out, rise_out, fall_out, edge_cnt_out);
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            total++;
            if ({q_out, rise_out, fall_out, edge_cnt_out} !== '0) begin
                bad++;
                $display("FAIL reset_hold k=%0d got q%b r%b f%b c%0d want all 0",
                         k, q_out, rise_out, fall_out, edge_cnt_out);
            end
        end
        d_in = 0;
        reset_n = 1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_clean_rise();
        d_in = 1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            total++;
            if ({q_out, rise_out, fall_out, edge_cnt_out} !== {k >= 6, k == 6, 1'b0, CW'(k >= 6)}) begin
                bad++;
                $display("FAIL clean_rise edge=%0d got q%b r%b f%b c%0d want q%b r%b f0 c%0d",
                         k, q_out, rise_out, fall_out, edge_cnt_out, k >= 6, k == 6, k >= 6);
            end
            total++;
            if ({q_out, rise_out, fall_out, edge_cnt_out} !== {m_q, m_rise, m_fall, m_cnt}) begin
                bad++;
                $display("FAIL clean_rise_model edge=%0d got q%b r%b f%b c%0d want q%b r%b f%b c%0d",
                         k, q_out, rise_out, fall_out, edge_cnt_out, m_q, m_rise, m_fall, m_cnt);
            end
        end
    endtask

    task automatic test_clean_fall();
        d_in = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            total++;
            if ({q_out, rise_out, fall_out, edge_cnt_out} !== {k < 6, 1'b0, k == 6, CW'(1)}) begin
                bad++;
                $display("FAIL clean_fall edge=%0d got q%b r%b f%b c%0d want q%b r0 f%b c1",
                         k, q_out, rise_out, fall_out, edge_cnt_out, k < 6, k == 6);
            end
        end
    endtask

    task automatic test_bounce();
        cnt_clr_in = 1;
        @(negedge clk);
        cnt_clr_in = 0;
        total++;
        if (edge_cnt_out !== '0) begin
            bad++;
            $display("FAIL bounce_clear got c%0d want 0", edge_cnt_out);
        end
        for (int rep = 0; rep < 5; rep++) begin
            for (int i = 0; i < 8; i++) begin
                d_in = ((i % 4) != 3);
                @(negedge clk);
                total++;
                if ({q_out, rise_out, fall_out, edge_cnt_out} !== {3'b000, CW'(0)}) begin
                    bad++;
                    $display("FAIL bounce rep=%0d i=%0d got q%b r%b f%b c%0d want q0 r0 f0 c0",
                             rep, i, q_out, rise_out, fall_out, edge_cnt_out);
                end
            end
        end
        d_in = 1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            total++;
            if ({q_out, rise_out, fall_out, edge_cnt_out} !== {k >= 6, k == 6, 1'b0, CW'(k >= 6)}) begin
                bad++;
                $display("FAIL bounce_hold edge=%0d got q%b r%b f%b c%0d want q%b r%b f0 c%0d",
                         k, q_out, rise_out, fall_out, edge_cnt_out, k >= 6, k == 6, k >= 6);
            end
        end
    endtask

    task automatic test_wrap_clear();
        int h;
        cnt_clr_in = 1;
        @(negedge clk);
        cnt_clr_in = 0;
        for (int p = 0; p < 257; p++) begin
            for (int half = 0; half < 2; half++) begin
                d_in = (half == 1);
                h = $urandom_range(6, 9);
                for (int k = 0; k < h; k++) begin
                    @(negedge clk);
                    total++;
                    if ({q_out, rise_out, fall_out, edge_cnt_out} !== {m_q, m_rise, m_fall, m_cnt}) begin
                        bad++;
                        $display("FAIL wrap_model p=%0d got q%b r%b f%b c%0d want q%b r%b f%b c%0d",
                                 p, q_out, rise_out, fall_out, edge_cnt_out, m_q, m_rise, m_fall, m_cnt);
                    end
                end
            end
            if (p == 255) begin
                total++;
                if ({q_out, edge_cnt_out} !== {1'b1, CW'(0)}) begin
                    bad++;
                    $display("FAIL wrap_256 got q%b c%0d want q1 c0", q_out, edge_cnt_out);
                end
            end
        end
        total++;
        if (edge_cnt_out !== CW'(1)) begin
            bad++;
            $display("FAIL wrap_257 got c%0d want 1", edge_cnt_out);
        end
        d_in = 0;
        repeat (8) @(negedge clk);
        d_in = 1;
        for (int k = 1; k <= 8; k++) begin
            cnt_clr_in = (k == 6);
            @(negedge clk);
            if (k == 6) begin
                total++;
                if ({rise_out, edge_cnt_out} !== {1'b1, CW'(0)}) begin
                    bad++;
                    $display("FAIL clear_vs_rise got r%b c%0d want r1 c0", rise_out, edge_cnt_out);
                end
            end
        end
        cnt_clr_in = 0;
        total++;
        if (edge_cnt_out !== CW'(0)) begin
            bad++;
            $display("FAIL clear_after got c%0d want 0", edge_cnt_out);
        end
    endtask

    task automatic test_reset_mid_window();
        d_in = 0;
        repeat (8) @(negedge clk);
        d_in = 1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            total++;
            if (rise_out !== 1'b0 || q_out !== 1'b0) begin
                bad++;
                $display("FAIL mid_pre k=%0d got q%b r%b want q0 r0", k, q_out, rise_out);
            end
        end
        reset_n = 0;
        @(negedge clk);
        total++;
        if ({q_out, rise_out, fall_out, edge_cnt_out} !== '0) begin
            bad++;
            $display("FAIL mid_in_reset got q%b r%b f%b c%0d want all 0",
                     q_out, rise_out, fall_out, edge_cnt_out);
        end
        reset_n = 1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            total++;
            if ({q_out, rise_out, fall_out, edge_cnt_out} !== {k >= 6, k == 6, 1'b0, CW'(k >= 6)}) begin
                bad++;
                $display("FAIL mid_post edge=%0d got q%b r%b f%b c%0d want q%b r%b f0 c%0d",
                         k, q_out, rise_out, fall_out, edge_cnt_out, k >= 6, k == 6, k >= 6);
            end
        end
    endtask

    task automatic test_random();
        int   h;
        logic prev_pulse = 1'b0;
        for (int seg = 0; seg < 120; seg++) begin
            d_in = 1'($urandom_range(0, 1));
            h = $urandom_range(1, 8);
            for (int k = 0; k < h; k++) begin
                cnt_clr_in = ($urandom_range(0, 39) == 0);
                @(negedge clk);
                total++;
                if ({q_out, rise_out, fall_out, edge_cnt_out} !== {m_q, m_rise, m_fall, m_cnt}) begin
                    bad++;
                    $display("FAIL random_model seg=%0d got q%b r%b f%b c%0d want q%b r%b f%b c%0d",
                             seg, q_out, rise_out, fall_out, edge_cnt_out, m_q, m_rise, m_fall, m_cnt);
                end
                total++;
                if ((rise_out && fall_out) || (prev_pulse && (rise_out || fall_out))) begin
                    bad++;
                    $display("FAIL random_pulse seg=%0d got r%b f%b prev%b want single isolated pulse",
                             seg, rise_out, fall_out, prev_pulse);
                end
                prev_pulse = rise_out | fall_out;
            end
        end
        cnt_clr_in = 0;
    endtask

    initial begin
        test_reset();
        test_clean_rise();
        test_clean_fall();
        test_bounce();
        test_wrap_clear();
        test_reset_mid_window();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
